// File: rtl/fir_mac_engine.sv
// Serial multiply-accumulate FIR engine fed by decoded register fields.
// Latency: result valid Neff edges after sample accept; one tap per clock.
// Backpressure: holds result in OUT until out_ready; sample/coeff writes stall while busy.
module fir_mac_engine #(
  parameter int MAX_TAPS    = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int OUT_WIDTH   = 32,
  localparam int TW         = $clog2(MAX_TAPS),
  localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + TW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [TW:0]                   tap_count_i,
  input  logic                          coeff_reset_i,
  input  logic                          coeff_valid_i,
  input  logic signed [COEFF_WIDTH-1:0] coeff_data_i,
  output logic                          coeff_ready_o,
  input  logic                          sample_valid_i,
  input  logic signed [DATA_WIDTH-1:0]  sample_data_i,
  output logic                          sample_ready_o,
  output logic                          out_valid_o,
  output logic signed [OUT_WIDTH-1:0]   out_data_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic [TW-1:0]                 coeff_ptr_o
);

  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state, state_next;
  logic signed [DATA_WIDTH-1:0]  x [MAX_TAPS];
  logic signed [COEFF_WIDTH-1:0] c [MAX_TAPS];
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [PW-1:0]          prod;
  logic [TW-1:0]                 idx;
  logic [TW:0]                   neff;
  logic [TW:0]                   neff_req;
  logic [TW-1:0]                 ptr;
  logic                          accept;
  logic                          coeff_wr;
  logic                          last_tap;

  assign coeff_ready_o  = (state == IDLE);
  assign sample_ready_o = enable_i & (state == IDLE);
  assign out_valid_o    = (state == OUT);
  assign busy_o         = (state != IDLE);
  assign coeff_ptr_o    = ptr;
  assign accept         = sample_valid_i & sample_ready_o;
  assign coeff_wr       = coeff_valid_i & coeff_ready_o;

  // A tap count of zero still runs one tap; oversize requests clamp to the storage depth.
  assign neff_req = (tap_count_i == '0) ? (TW+1)'(1) :
                    (tap_count_i > (TW+1)'(MAX_TAPS)) ? (TW+1)'(MAX_TAPS) : tap_count_i;

  assign prod     = x[idx] * c[idx];
  assign acc_sum  = acc + {{TW{prod[PW-1]}}, prod};
  assign last_tap = ({1'b0, idx} == neff - (TW+1)'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode: accept -> MAC over Neff taps -> hold result until consumed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (last_tap) state_next = OUT;
      OUT:     if (out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Delay line, tap counter, accumulator and saturated result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_TAPS; k++) x[k] <= '0;
      acc        <= '0;
      idx        <= '0;
      neff       <= (TW+1)'(1);
      out_data_o <= '0;
    end else if (accept) begin
      x[0] <= sample_data_i;
      for (int k = 1; k < MAX_TAPS; k++) x[k] <= x[k-1];
      neff <= neff_req;
      acc  <= '0;
      idx  <= '0;
    end else if (state == MAC) begin
      acc <= acc_sum;
      idx <= idx + 1'b1;
      if (last_tap) begin
        if (acc_sum > SAT_MAX)      out_data_o <= SAT_MAX[OUT_WIDTH-1:0];
        else if (acc_sum < SAT_MIN) out_data_o <= SAT_MIN[OUT_WIDTH-1:0];
        else                        out_data_o <= acc_sum[OUT_WIDTH-1:0];
      end
    end
  end

  // Coefficient store; a pointer reset coinciding with a write lands that write at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_TAPS; k++) c[k] <= '0;
      ptr <= '0;
    end else if (coeff_reset_i) begin
      if (coeff_wr) begin
        c[0] <= coeff_data_i;
        ptr  <= TW'(1);
      end else begin
        ptr  <= '0;
      end
    end else if (coeff_wr) begin
      c[ptr] <= coeff_data_i;
      ptr    <= (ptr == TW'(MAX_TAPS-1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
Serial multiply-accumulate FIR datapath, sitting directly downstream of the FIR AXI-Lite register block. It consumes the decoded register fields: control enable, tap count, coefficient-data writes and input-data writes. For each accepted input sample it computes one filter output using one tap per cycle, then presents the result for the output-data register read path.

Parameters:
MAX_TAPS, 16, delay-line and coefficient storage depth
DATA_WIDTH, 16, signed input sample width
COEFF_WIDTH, 16, signed coefficient width
OUT_WIDTH, 32, signed output width (AXI_DATA_WIDTH)
ACC_WIDTH, DATA_WIDTH+COEFF_WIDTH+clogb2(MAX_TAPS), internal accumulator width (36 at defaults)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable_i  in  1  control register bit 0; gates sample acceptance
tap_count_i  in  clogb2(MAX_TAPS)+1  requested tap count N
coeff_reset_i  in  1  pulse; returns the coefficient write pointer to 0
coeff_valid_i  in  1  coefficient write strobe
coeff_data_i  in  COEFF_WIDTH  signed coefficient
coeff_ready_o  out  1  coefficient write accepted this cycle
sample_valid_i  in  1  input sample strobe
sample_data_i  in  DATA_WIDTH  signed sample
sample_ready_o  out  1  sample accepted this cycle
out_valid_o  out  1  result available
out_data_o  out  OUT_WIDTH  signed saturated result
out_ready_i  in  1  result consumed
busy_o  out  1  state != IDLE
coeff_ptr_o  out  clogb2(MAX_TAPS)  next coefficient write index

Behaviour:
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset clears: all outputs to 0, state IDLE, delay line, coefficient array, accumulator and pointer.
- FSM states are IDLE, MAC and OUT.
- sample_ready_o = enable_i & (state==IDLE). coeff_ready_o = (state==IDLE).
- Coefficient write, on coeff_valid_i & coeff_ready_o:
  - c[ptr] <= coeff_data_i; ptr <= ptr+1.
  - ptr wraps from MAX_TAPS-1 to 0.
- coeff_reset_i:
  - Sets ptr to 0 in any state.
  - If a write also occurs in the same cycle, the write lands at index 0 and ptr becomes 1.
- Sample accept in IDLE, on sample_valid_i & sample_ready_o:
  - Delay line shifts: x[0] <= sample, x[k] <= x[k-1]; x[MAX_TAPS-1] is dropped.
  - Latch Neff = clamp(tap_count_i): 0 is treated as 1; values above MAX_TAPS are treated as MAX_TAPS.
  - Clear acc and idx; go to MAC.
- MAC, one tap per clock edge:
  - acc <= acc + sign_ext(x[idx]*c[idx]); idx++.
  - c[0] multiplies the newest sample.
  - The edge processing idx==Neff-1 registers out_data_o = sat(final acc) and moves to OUT.
- sat(): clamps the ACC_WIDTH value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- OUT:
  - out_valid_o=1; out_data_o held stable.
  - On out_ready_i, go to IDLE and drop out_valid_o on the next edge.
  - Back-to-back case: if sample_valid_i is high, it is accepted on the edge after the OUT→IDLE transition.
- Latency: out_valid_o is visible Neff clock edges after the accepting edge. Throughput is one sample per Neff+2 cycles when out_ready_i is held high.
- enable_i deasserted mid-MAC/OUT: the current computation completes normally; only new acceptance is blocked.
- tap_count_i and coefficient changes while busy:
  - tap_count_i changes have no effect until the next accept.
  - Coefficient writes are stalled, because coeff_ready_o is low.
- Delay-line entries beyond Neff are retained. Raising N later uses the real history.
- rst asserted mid-operation: immediate return to reset state; any in-flight result is discarded.
- busy_o is combinational from state.

Test Plan:
- Reset: assert rst with random inputs → out_valid_o=0, out_data_o=0, busy_o=0, coeff_ptr_o=0, sample_ready_o=enable_i.
- Identity: write coeff 1, N=1, enable, sample 5 → out_valid_o one edge after accept, out_data_o=5, coeff_ptr_o=1.
- Moving sum: write coeffs 1,1,1,1; N=4; samples 1,2,3,4,5 → outputs 1,3,6,10,14, each out_valid_o 4 edges after its accept; check sample_ready_o low while busy.
- Saturation: 16 coeffs −32768, N=16, sixteen samples of −32768 → last output 0x7FFFFFFF; repeat with coeff +32767 → value 16·(−32768·32767) = −17179344896 → out_data_o 0x80000000.
- Backpressure/clamp: N=20, out_ready_i low 10 cycles → 16-cycle MAC, out_valid_o/out_data_o stable, coeff_ready_o and sample_ready_o low; coeff_reset_i with coeff_valid_i in IDLE → write at index 0, ptr=1.
- Reset mid-MAC: assert rst at idx=2 of N=8 → all outputs 0 asynchronously, no out_valid_o afterwards; new sample after release computes from a zeroed delay line and coefficient array.
